tb_dinb_wb_map: RTL and testbench

//  Write-back mapper from the systolic array result side into TB port b.

---
 rtl/tb_dinb_wb_map_if.sv | 36 +++
 rtl/tb_dinb_wb_map.sv | 117 +++++++++++
 tb/tb_tb_dinb_wb_map.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tb_dinb_wb_map_if.sv
// Bundle of write-back mapper control, array result streams and TB port b signals.
// The master side drives jobs and result rows; the slave side is the mapper.
interface tb_dinb_wb_map_if #(
    parameter int X      = 4,
    parameter int L      = 4,
    parameter int RSA_DW = 16,
    parameter int RSA_AW = 10
) ();
    logic [2:0]          TB_dinb_sel;
    logic                wb_start;
    logic [RSA_AW-1:0]   wb_base_addr;
    logic [RSA_AW-1:0]   wb_len;
    logic [X*RSA_DW-1:0] C_data;
    logic                C_valid;
    logic [X*RSA_DW-1:0] C_CONS_data;
    logic                C_CONS_valid;
    logic                C_ready;
    logic                TB_enb;
    logic                TB_web;
    logic [RSA_AW-1:0]   TB_addrb;
    logic [L*RSA_DW-1:0] TB_dinb;
    logic                wb_busy;
    logic                wb_done;

    modport master (
        output TB_dinb_sel, wb_start, wb_base_addr, wb_len,
        output C_data, C_valid, C_CONS_data, C_CONS_valid,
        input  C_ready, TB_enb, TB_web, TB_addrb, TB_dinb, wb_busy, wb_done
    );

    modport slave (
        input  TB_dinb_sel, wb_start, wb_base_addr, wb_len,
        input  C_data, C_valid, C_CONS_data, C_CONS_valid,
        output C_ready, TB_enb, TB_web, TB_addrb, TB_dinb, wb_busy, wb_done
    );
endinterface

// File: rtl/tb_dinb_wb_map.sv
// Write-back mapper: turns array result rows (C or C_CONS) into TB port b writes
// over wb_len consecutive rows, with POS/NEG lane ordering or a zero-fill job.
module tb_dinb_wb_map #(
    parameter int X      = 4,
    parameter int Y      = 4,
    parameter int L      = 4,
    parameter int RSA_DW = 16,
    parameter int RSA_AW = 10
) (
    input logic           clk,
    input logic           sys_rst,
    tb_dinb_wb_map_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_ZERO = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_NEG  = 2'b10;
    localparam logic [1:0] MODE_NEW  = 2'b11;

    // An illegal lane configuration leaves an empty marker block in the hierarchy.
    if (L < X || Y < 1) begin : g_bad_cfg
    end

    logic [1:0]          state;
    logic [2:0]          sel_q;
    logic [RSA_AW-1:0]   base_q;
    logic [RSA_AW-1:0]   len_q;
    logic [RSA_AW-1:0]   cnt;
    logic [RSA_AW-1:0]   cnt_nxt;
    logic [X*RSA_DW-1:0] src_data;
    logic                src_valid;
    logic                accept;
    logic [L*RSA_DW-1:0] mapped;

    assign src_data  = sel_q[2] ? bus.C_CONS_data  : bus.C_data;
    assign src_valid = sel_q[2] ? bus.C_CONS_valid : bus.C_valid;
    assign cnt_nxt   = cnt + 1'b1;

    assign bus.C_ready = (state == S_RUN) && (cnt < len_q);
    assign bus.wb_busy = (state != S_IDLE);
    assign accept      = bus.C_ready && src_valid;

    // Lane reorder into the TB word; lanes above X stay zero.
    always_comb begin
        mapped = '0;
        for (int i = 0; i < X; i++) begin
            if (sel_q[1:0] == MODE_NEG)
                mapped[i*RSA_DW +: RSA_DW] = src_data[(X-1-i)*RSA_DW +: RSA_DW];
            else
                mapped[i*RSA_DW +: RSA_DW] = src_data[i*RSA_DW +: RSA_DW];
        end
    end

    // Job sequencing and the registered TB port b drive; address/data hold between writes.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= S_IDLE;
            sel_q        <= '0;
            base_q       <= '0;
            len_q        <= '0;
            cnt          <= '0;
            bus.TB_enb   <= 1'b0;
            bus.TB_web   <= 1'b0;
            bus.TB_addrb <= '0;
            bus.TB_dinb  <= '0;
            bus.wb_done  <= 1'b0;
        end else begin
            bus.TB_enb  <= 1'b0;
            bus.TB_web  <= 1'b0;
            bus.wb_done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (bus.wb_start) begin
                        sel_q  <= bus.TB_dinb_sel;
                        base_q <= bus.wb_base_addr;
                        len_q  <= bus.wb_len;
                        cnt    <= '0;
                        if (bus.wb_len == '0 || bus.TB_dinb_sel[1:0] == MODE_IDLE)
                            state <= S_DONE;
                        else if (bus.TB_dinb_sel[1:0] == MODE_NEW)
                            state <= S_ZERO;
                        else
                            state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        bus.TB_enb   <= 1'b1;
                        bus.TB_web   <= 1'b1;
                        bus.TB_addrb <= base_q + cnt;
                        bus.TB_dinb  <= mapped;
                        cnt          <= cnt_nxt;
                        if (cnt_nxt == len_q)
                            state <= S_DONE;
                    end
                end
                S_ZERO: begin
                    bus.TB_enb   <= 1'b1;
                    bus.TB_web   <= 1'b1;
                    bus.TB_addrb <= base_q + cnt;
                    bus.TB_dinb  <= '0;
                    cnt          <= cnt_nxt;
                    if (cnt_nxt == len_q)
                        state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tb_dinb_wb_map.sv
// Self-checking bench for tb_dinb_wb_map: job-level reference model checked every
// cycle, directed scenarios pinned with literal expectations, then random jobs.
module tb_tb_dinb_wb_map;

    localparam int X  = 4;
    localparam int Y  = 4;
    localparam int L  = 6;
    localparam int DW = 16;
    localparam int AW = 10;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [L*DW-1:0] data;
        int              cyc;
    } wr_t;

    logic clk = 1'b0;
    logic sys_rst;

    always #5 clk = ~clk;

    tb_dinb_wb_map_if #(.X(X), .L(L), .RSA_DW(DW), .RSA_AW(AW)) bus ();

    tb_dinb_wb_map #(.X(X), .Y(Y), .L(L), .RSA_DW(DW), .RSA_AW(AW)) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: job phase 0 idle, 1 writing, 2 finishing, 3 done pulse.
    int              m_phase = 0;
    int              m_cnt = 0;
    int              m_len = 0;
    int              m_base = 0;
    logic [2:0]      m_sel = '0;
    bit              e_enb = 1'b0;
    bit              e_ready;
    logic [AW-1:0]   e_addr = '0;
    logic [L*DW-1:0] e_din = '0;

    int  cyc = 0;
    int  done_cyc = 0;
    int  done_count = 0;
    int  start_cyc = 0;
    wr_t wlog[$];

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [X*DW-1:0] row_val(input int r);
        logic [X*DW-1:0] v;
        for (int j = 0; j < X; j++) v[j*DW +: DW] = DW'(r * 4 + j);
        return v;
    endfunction

    function automatic logic [L*DW-1:0] map_row(input logic [X*DW-1:0] src, input bit neg);
        logic [DW-1:0]   lanes [X];
        logic [L*DW-1:0] res;
        res = '0;
        for (int i = 0; i < X; i++) lanes[i] = src[i*DW +: DW];
        for (int i = 0; i < X; i++) res[i*DW +: DW] = neg ? lanes[X-1-i] : lanes[i];
        return res;
    endfunction

    function automatic int wl_addr(input int i);
        return (i < wlog.size()) ? int'(wlog[i].addr) : -1;
    endfunction

    function automatic logic [L*DW-1:0] wl_data(input int i);
        return (i < wlog.size()) ? wlog[i].data : '1;
    endfunction

    function automatic int wl_cyc(input int i);
        return (i < wlog.size()) ? wlog[i].cyc : -100;
    endfunction

    // Compare outputs against the model each cycle, then advance the model past the next edge.
    always @(negedge clk) begin
        cyc++;
        if (sys_rst) begin
            check_output("rst_ready", bus.C_ready, 0);
            check_output("rst_enb",   bus.TB_enb, 0);
            check_output("rst_web",   bus.TB_web, 0);
            check_output("rst_addr",  bus.TB_addrb, 0);
            check_output("rst_dinb",  bus.TB_dinb, 0);
            check_output("rst_busy",  bus.wb_busy, 0);
            check_output("rst_done",  bus.wb_done, 0);
            m_phase = 0;
            e_enb   = 1'b0;
            e_addr  = '0;
            e_din   = '0;
        end else begin
            e_ready = (m_phase == 1) && (m_sel[1:0] == 2'b01 || m_sel[1:0] == 2'b10) && (m_cnt < m_len);
            check_output("ready", bus.C_ready, e_ready);
            check_output("enb",   bus.TB_enb, e_enb);
            check_output("web",   bus.TB_web, e_enb);
            check_output("addr",  bus.TB_addrb, e_addr);
            check_output("dinb",  bus.TB_dinb, e_din);
            check_output("busy",  bus.wb_busy, (m_phase == 1 || m_phase == 2));
            check_output("done",  bus.wb_done, (m_phase == 3));
            if (bus.TB_enb) wlog.push_back('{bus.TB_addrb, bus.TB_dinb, cyc});
            if (bus.wb_done) begin
                done_cyc = cyc;
                done_count++;
            end
            e_enb = 1'b0;
            if (m_phase == 0 || m_phase == 3) begin
                m_phase = 0;
                if (bus.wb_start) begin
                    start_cyc = cyc;
                    m_sel     = bus.TB_dinb_sel;
                    m_base    = int'(bus.wb_base_addr);
                    m_len     = int'(bus.wb_len);
                    m_cnt     = 0;
                    m_phase   = (m_len == 0 || m_sel[1:0] == 2'b00) ? 2 : 1;
                end
            end else if (m_phase == 1) begin
                if (m_sel[1:0] == 2'b11) begin
                    e_enb  = 1'b1;
                    e_addr = AW'((m_base + m_cnt) % (1 << AW));
                    e_din  = '0;
                    m_cnt++;
                end else if (e_ready && (m_sel[2] ? bus.C_CONS_valid : bus.C_valid)) begin
                    e_enb  = 1'b1;
                    e_addr = AW'((m_base + m_cnt) % (1 << AW));
                    e_din  = map_row(m_sel[2] ? bus.C_CONS_data : bus.C_data, m_sel[1:0] == 2'b10);
                    m_cnt++;
                end
                if (m_cnt == m_len) m_phase = 2;
            end else begin
                m_phase = 3;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.TB_dinb_sel  = '0;
        bus.wb_start     = 1'b0;
        bus.wb_base_addr = '0;
        bus.wb_len       = '0;
        bus.C_data       = '0;
        bus.C_valid      = 1'b0;
        bus.C_CONS_data  = '0;
        bus.C_CONS_valid = 1'b0;
    endtask

    // Random result traffic, with occasional stray starts that must be ignored while busy.
    task automatic apply_stimulus();
        bus.C_valid      = ($urandom_range(0, 3) != 0);
        bus.C_CONS_valid = ($urandom_range(0, 2) != 0);
        bus.C_data       = {$urandom, $urandom};
        bus.C_CONS_data  = {$urandom, $urandom};
        if ((m_phase == 1 || m_phase == 2) && $urandom_range(0, 7) == 0) begin
            bus.wb_start     = 1'b1;
            bus.TB_dinb_sel  = 3'($urandom);
            bus.wb_base_addr = AW'($urandom);
            bus.wb_len       = AW'($urandom_range(1, 5));
        end else begin
            bus.wb_start = 1'b0;
        end
    endtask

    task automatic start_job(input logic [2:0] sel, input logic [AW-1:0] base, input logic [AW-1:0] len);
        bus.TB_dinb_sel  = sel;
        bus.wb_base_addr = base;
        bus.wb_len       = len;
        bus.wb_start     = 1'b1;
        tick();
        bus.wb_start     = 1'b0;
        bus.TB_dinb_sel  = 3'($urandom);
        bus.wb_base_addr = AW'($urandom);
        bus.wb_len       = AW'($urandom);
    endtask

    task automatic wait_job_end(input int budget, input bit rnd);
        int n = 0;
        while (m_phase != 0 && n < budget) begin
            if (rnd) apply_stimulus();
            tick();
            n++;
        end
        bus.wb_start     = 1'b0;
        bus.C_valid      = 1'b0;
        bus.C_CONS_valid = 1'b0;
        if (m_phase != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL job_timeout actual=phase%0d required=phase0 after %0d cycles", m_phase, budget);
        end
    endtask

    initial begin
        int done_before;
        sys_rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1 sys_rst = 1'b0;
        tick();

        $display("[TB] POS write-back");
        wlog.delete();
        start_job(3'b001, 10'h010, 10'd3);
        for (int r = 1; r <= 3; r++) begin
            bus.C_valid = 1'b1;
            bus.C_data  = row_val(r);
            tick();
        end
        bus.C_valid = 1'b0;
        wait_job_end(20, 1'b0);
        check_output("pos_count", wlog.size(), 3);
        check_output("pos_addr0", wl_addr(0), 'h010);
        check_output("pos_addr2", wl_addr(2), 'h012);
        check_output("pos_data1", wl_data(1), 96'h0000_0000_000b_000a_0009_0008);
        check_output("pos_done_lag", done_cyc - wl_cyc(2), 1);

        $display("[TB] NEG lane reversal");
        wlog.delete();
        start_job(3'b010, 10'h100, 10'd1);
        bus.C_valid = 1'b1;
        bus.C_data  = {16'd4, 16'd3, 16'd2, 16'd1};
        tick();
        bus.C_valid = 1'b0;
        wait_job_end(20, 1'b0);
        check_output("neg_data", wl_data(0), 96'h0000_0000_0001_0002_0003_0004);

        $display("[TB] C_CONS source with bubbles");
        wlog.delete();
        start_job(3'b101, 10'h020, 10'd4);
        for (int k = 0; k < 10; k++) begin
            bus.C_valid      = 1'b1;
            bus.C_data       = {$urandom, $urandom};
            bus.C_CONS_valid = (k % 2 == 0);
            bus.C_CONS_data  = row_val(10 + k);
            tick();
        end
        wait_job_end(20, 1'b0);
        check_output("cons_count", wlog.size(), 4);
        check_output("cons_addr3", wl_addr(3), 'h023);
        check_output("cons_data1", wl_data(1), 96'h0000_0000_0033_0032_0031_0030);

        $display("[TB] NEW zero fill with wrap");
        wlog.delete();
        start_job(3'b011, 10'h3FE, 10'd4);
        wait_job_end(20, 1'b1);
        check_output("new_count", wlog.size(), 4);
        check_output("new_addr0", wl_addr(0), 'h3FE);
        check_output("new_addr1", wl_addr(1), 'h3FF);
        check_output("new_addr2", wl_addr(2), 'h000);
        check_output("new_addr3", wl_addr(3), 'h001);
        check_output("new_data2", wl_data(2), 0);

        $display("[TB] degenerate jobs");
        wlog.delete();
        start_job(3'b001, 10'h050, 10'd0);
        wait_job_end(20, 1'b0);
        check_output("len0_writes", wlog.size(), 0);
        check_output("len0_done_lag", done_cyc - start_cyc, 2);
        start_job(3'b100, 10'h050, 10'd5);
        wait_job_end(20, 1'b0);
        check_output("idle_writes", wlog.size(), 0);
        check_output("idle_done_lag", done_cyc - start_cyc, 2);

        $display("[TB] start while busy");
        wlog.delete();
        start_job(3'b011, 10'h200, 10'd6);
        tick();
        bus.TB_dinb_sel  = 3'b001;
        bus.wb_base_addr = 10'h300;
        bus.wb_len       = 10'd2;
        bus.wb_start     = 1'b1;
        tick();
        bus.wb_start = 1'b0;
        wait_job_end(20, 1'b0);
        check_output("busy_count", wlog.size(), 6);
        check_output("busy_addr5", wl_addr(5), 'h205);

        $display("[TB] reset mid-run");
        wlog.delete();
        done_before = done_count;
        start_job(3'b001, 10'h040, 10'd5);
        for (int r = 1; r <= 2; r++) begin
            bus.C_valid = 1'b1;
            bus.C_data  = row_val(r);
            tick();
        end
        bus.C_valid = 1'b0;
        tick();
        sys_rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 sys_rst = 1'b0;
        repeat (4) tick();
        check_output("rst_writes", wlog.size(), 2);
        check_output("rst_no_done", done_count, done_before);

        $display("[TB] random jobs");
        for (int j = 0; j < 40; j++) begin
            start_job(3'($urandom), AW'($urandom), AW'($urandom_range(0, 6)));
            wait_job_end(200, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
